// File: rtl/enable_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : enable_gen_if
//  Purpose  : Control/status bundle between a controller and enable_gen.
//  Revision : 1.0 - initial release
// ============================================================================
interface enable_gen_if #(
    parameter int PERIOD  = 8,
    parameter int BURST_W = 4
) ();
    localparam int PH_W = $clog2(PERIOD);

    logic               start;
    logic               stop;
    logic [BURST_W-1:0] bursts;
    logic               en;
    logic [PH_W-1:0]    phase;
    logic               busy;
    logic               done;

    modport master (
        output start, stop, bursts,
        input  en, phase, busy, done
    );

    modport slave (
        input  start, stop, bursts,
        output en, phase, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/enable_gen.sv
`default_nettype none
// ============================================================================
//  Module   : enable_gen
//  Purpose  : Periodic count-enable generator (burst or continuous), with
//             start/stop control. Optional macro ENABLE_GEN_IMMEDIATE_STOP_EN
//             ends a burst on the stop edge instead of at the next wrap.
//  Revision : 1.0 - initial release
// ============================================================================
module enable_gen #(
    parameter int PERIOD     = 8,
    parameter int LOW_CYCLES = 2,
    parameter int BURST_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    enable_gen_if.slave bus
);
    localparam int              PH_W   = $clog2(PERIOD);
    localparam logic [PH_W-1:0] c_last = PH_W'(PERIOD - 1);
    // One extra bit: with LOW_CYCLES=0 the threshold equals PERIOD itself.
    localparam logic [PH_W:0]   c_high = (PH_W + 1)'(PERIOD - LOW_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [BURST_W-1:0] r_bursts;
    logic [BURST_W-1:0] r_cnt;
    logic [PH_W-1:0]    r_phase;
    logic               r_en;
    logic               r_busy;
    logic               r_done;

    logic               w_wrap;
    logic [PH_W-1:0]    w_phase_nxt;
    logic [BURST_W-1:0] w_cnt_nxt;
    logic               w_last_period;
    logic               w_end;

    assign w_wrap        = (r_phase == c_last);
    assign w_phase_nxt   = w_wrap ? '0 : r_phase + PH_W'(1);
    assign w_cnt_nxt     = r_cnt + BURST_W'(1);
    assign w_last_period = (r_bursts != '0) && (w_cnt_nxt == r_bursts);

`ifdef ENABLE_GEN_IMMEDIATE_STOP_EN
    assign w_end = bus.stop || (w_wrap && w_last_period);
`else
    logic r_stop_pend;
    assign w_end = w_wrap && (w_last_period || r_stop_pend);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_bursts <= '0;
            r_cnt    <= '0;
            r_phase  <= '0;
            r_en     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifndef ENABLE_GEN_IMMEDIATE_STOP_EN
            r_stop_pend <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state  <= ST_RUN;
                        r_bursts <= bus.bursts;
                        r_cnt    <= '0;
                        r_phase  <= '0;
                        r_busy   <= 1'b1;
                        r_en     <= (LOW_CYCLES < PERIOD);
                    end
                end
                ST_RUN: begin
                    if (w_wrap) begin
                        r_cnt <= w_cnt_nxt;
                    end
                    if (w_end) begin
                        r_state <= ST_DONE;
                        r_phase <= '0;
                        r_en    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_phase <= w_phase_nxt;
                        r_en    <= ({1'b0, w_phase_nxt} < c_high);
                    end
`ifndef ENABLE_GEN_IMMEDIATE_STOP_EN
                    // Sticky until the generator returns to IDLE.
                    if (bus.stop) begin
                        r_stop_pend <= 1'b1;
                    end
`endif
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
`ifndef ENABLE_GEN_IMMEDIATE_STOP_EN
                    r_stop_pend <= 1'b0;
`endif
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.en    = r_en;
    assign bus.phase = r_phase;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
endmodule
`default_nettype wire

// File: tb/tb_enable_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_enable_gen
//  Purpose  : Self-checking bench; three instances (LOW_CYCLES 2/0/7) share
//             one set of controls and are compared against a cycle model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_enable_gen;
    localparam int P  = 8;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          stop;
    logic [BW-1:0] bursts;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    enable_gen_if #(.PERIOD(P), .BURST_W(BW)) bus  ();
    enable_gen_if #(.PERIOD(P), .BURST_W(BW)) bus0 ();
    enable_gen_if #(.PERIOD(P), .BURST_W(BW)) bus7 ();

    assign bus.start  = start;  assign bus.stop  = stop;  assign bus.bursts  = bursts;
    assign bus0.start = start;  assign bus0.stop = stop;  assign bus0.bursts = bursts;
    assign bus7.start = start;  assign bus7.stop = stop;  assign bus7.bursts = bursts;

    enable_gen #(.PERIOD(P), .LOW_CYCLES(2), .BURST_W(BW)) dut  (.clk(clk), .reset(reset), .bus(bus));
    enable_gen #(.PERIOD(P), .LOW_CYCLES(0), .BURST_W(BW)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    enable_gen #(.PERIOD(P), .LOW_CYCLES(7), .BURST_W(BW)) dut7 (.clk(clk), .reset(reset), .bus(bus7));

    // {en(L=2), en(L=0), en(L=7), phase, busy, done}
    logic [7:0] obs;
    assign obs = {bus.en, bus0.en, bus7.en, bus.phase, bus.busy, bus.done};

    // Reference: mode 0=idle 1=run 2=done; k = cycles elapsed since start.
    int m_mode = 0;
    int m_k    = 0;
    int m_bl   = 0;
    bit m_stp  = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_mode = 0; m_k = 0; m_stp = 1'b0;
        end else if (m_mode == 0) begin
            if (start) begin
                m_mode = 1; m_k = 0; m_bl = int'(bursts); m_stp = 1'b0;
            end
        end else if (m_mode == 1) begin
            bit at_end;
            bit fin;
            at_end = (m_k % P) == P - 1;
            fin = at_end && (m_bl != 0) && (((m_k + 1) / P) % (1 << BW) == m_bl);
`ifdef ENABLE_GEN_IMMEDIATE_STOP_EN
            if (fin || stop) m_mode = 2;
            else m_k++;
`else
            if (fin || (at_end && m_stp)) m_mode = 2;
            else m_k++;
            if (stop) m_stp = 1'b1;
`endif
        end else begin
            m_mode = 0;
        end
    end

    function automatic logic [7:0] expv();
        int ph;
        logic run;
        run = (m_mode == 1);
        ph  = run ? (m_k % P) : 0;
        return {run && (ph < P - 2), run && (ph < P - 0), run && (ph < P - 7),
                3'(ph), run, m_mode == 2};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; stop = 1'b0; bursts = '0;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (obs !== 8'b0) begin
                miscompares++;
                $display("FAIL reset_state cyc%0d: got %b expected %b", i, obs, 8'b0);
            end
        end
        reset = 1'b0;
        start = 1'b1; stop = 1'b1;
        reset = 1'b1;
        tick();
        vectors++;
        if (obs !== 8'b0) begin
            miscompares++;
            $display("FAIL reset_overrides_start: got %b expected %b", obs, 8'b0);
        end
        reset = 1'b0; start = 1'b0; stop = 1'b0;
        tick();
    endtask

    task automatic test_burst3();
        int first = -1, donecyc = -1, ens = 0;
        bursts = 4'd3; start = 1'b1;
        tick();
        start = 1'b0; bursts = 4'($urandom);
        for (int i = 0; i < 60; i++) begin
            vectors++;
            if (obs !== expv()) begin
                miscompares++;
                $display("FAIL burst3 cyc%0d: got %b expected %b", i, obs, expv());
            end
            if (bus.en) ens++;
            if (bus.en && first < 0) first = i;
            if (bus.done) donecyc = i;
            if (m_mode == 0) break;
            tick();
        end
        vectors++;
        if (ens != 18 || donecyc - first != 24 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL burst3_timing: got ens=%0d done_after=%0d busy=%b expected 18/24/0",
                     ens, donecyc - first, bus.busy);
        end
    endtask

    task automatic test_stop();
        int stopcyc = -1, donecyc = -1, exp_gap;
        bursts = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            vectors++;
            if (obs !== expv()) begin
                miscompares++;
                $display("FAIL stop cyc%0d: got %b expected %b", i, obs, expv());
            end
            if (bus.done) donecyc = i;
            stop = (m_mode == 1 && m_k == 11);
            if (stop) stopcyc = i;
            if (m_mode == 0) break;
            tick();
        end
        stop = 1'b0;
`ifdef ENABLE_GEN_IMMEDIATE_STOP_EN
        exp_gap = 1;
`else
        exp_gap = 5;
`endif
        vectors++;
        if (donecyc - stopcyc != exp_gap) begin
            miscompares++;
            $display("FAIL stop_latency: got %0d expected %0d", donecyc - stopcyc, exp_gap);
        end
    endtask

    task automatic test_start_ignored();
        int ens = 0, busy_after = 0;
        bursts = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            vectors++;
            if (obs !== expv()) begin
                miscompares++;
                $display("FAIL start_ignored cyc%0d: got %b expected %b", i, obs, expv());
            end
            if (bus.en) ens++;
            if (m_mode == 0) break;
            start  = (m_mode == 1 && m_k == 5) || (m_mode == 2);
            bursts = start ? 4'd7 : bursts;
            tick();
        end
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.busy) busy_after++;
        end
        vectors++;
        if (ens != 12 || busy_after != 0) begin
            miscompares++;
            $display("FAIL start_ignored_len: got ens=%0d busy_after=%0d expected 12/0", ens, busy_after);
        end
    endtask

    task automatic test_reset_mid();
        int ens = 0;
        bursts = 4'($urandom_range(1, 15)); start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10 && !(m_mode == 1 && m_k == 4); i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if (obs !== 8'b0) begin
            miscompares++;
            $display("FAIL reset_mid: got %b expected %b", obs, 8'b0);
        end
        bursts = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            vectors++;
            if (obs !== expv()) begin
                miscompares++;
                $display("FAIL reset_mid_restart cyc%0d: got %b expected %b", i, obs, expv());
            end
            if (bus.en) ens++;
            if (m_mode == 0) break;
            tick();
        end
        vectors++;
        if (ens != 6) begin
            miscompares++;
            $display("FAIL reset_mid_period: got ens=%0d expected 6", ens);
        end
    endtask

    task automatic test_low_extremes();
        int en0 = 0, en7 = 0, bad7 = 0;
        bursts = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            vectors++;
            if (obs !== expv()) begin
                miscompares++;
                $display("FAIL low_extremes cyc%0d: got %b expected %b", i, obs, expv());
            end
            if (bus0.en) en0++;
            if (bus7.en) en7++;
            if (bus7.en !== (bus7.busy && bus7.phase == 3'd0)) bad7++;
            if (m_mode == 0) break;
            tick();
        end
        vectors++;
        if (en0 != 16 || en7 != 2 || bad7 != 0) begin
            miscompares++;
            $display("FAIL low_extremes_count: got en0=%0d en7=%0d bad7=%0d expected 16/2/0", en0, en7, bad7);
        end
    endtask

    task automatic test_final_wrap_stop();
        int dones = 0;
        bursts = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            vectors++;
            if (obs !== expv()) begin
                miscompares++;
                $display("FAIL final_wrap_stop cyc%0d: got %b expected %b", i, obs, expv());
            end
            if (bus.done) dones++;
            stop = (m_mode == 1 && m_k == 7);
            tick();
        end
        stop = 1'b0;
        vectors++;
        if (dones != 1 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL final_wrap_stop_pulses: got dones=%0d busy=%b expected 1/0", dones, bus.busy);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            reset  = ($urandom_range(0, 199) == 0);
            start  = ($urandom_range(0, 7) == 0);
            stop   = ($urandom_range(0, 29) == 0);
            bursts = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
            tick();
            vectors++;
            if (obs !== expv()) begin
                miscompares++;
                $display("FAIL random cyc%0d: got %b expected %b", i, obs, expv());
            end
        end
        reset = 1'b0; start = 1'b0; stop = 1'b0;
    endtask

    initial begin
        test_reset();
        test_burst3();
        test_stop();
        test_start_ignored();
        test_reset_mid();
        test_low_extremes();
        test_final_wrap_stop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
